// File: rtl/writeback_unit_p.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_p
// Purpose  : Write-back stage. Retires ALU results and load returns into the
//            register file through a single write port. Updates NZCV flags.
//            Tracks in-order outstanding loads in a small index queue (LDQ)
//            and publishes a per-register busy scoreboard.
// Options  : WB_BYPASS_EN - adds byp_valid/byp_idx/byp_data, which show the
//            write that reg_w_* will carry on the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit_p #(
    parameter int DATA_W    = 16,
    parameter int REG_IDX_W = 5,
    parameter int LDQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ex_wb_valid,
    output logic                          ex_wb_ready,
    input  logic [DATA_W-1:0]             ex_wb_result,
    input  logic [3:0]                    ex_wb_nzcv,
    input  logic                          ex_wb_flags_we,
    input  logic                          ex_wb_reg_we,
    input  logic                          ex_wb_is_load,
    input  logic [REG_IDX_W-1:0]          ex_wb_reg_idx_dst,
    input  logic                          mem_r_valid,
    input  logic [DATA_W-1:0]             mem_r_data,
    output logic                          reg_w_en,
    output logic [REG_IDX_W-1:0]          reg_w_idx,
    output logic [DATA_W-1:0]             reg_w_data,
    output logic [3:0]                    flags_q,
    output logic [(2**REG_IDX_W)-1:0]     reg_busy,
    output logic [$clog2(LDQ_DEPTH):0]    ldq_count,
    output logic                          ldq_underflow
`ifdef WB_BYPASS_EN
    ,
    output logic                          byp_valid,
    output logic [REG_IDX_W-1:0]          byp_idx,
    output logic [DATA_W-1:0]             byp_data
`endif
);

    localparam int C_PTR_W = $clog2(LDQ_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_NREG  = 2 ** REG_IDX_W;

    // LDQ storage: destination index and valid bit per slot
    logic [REG_IDX_W-1:0] r_ldq_idx [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0] r_slot_vld;
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;

    logic [C_NREG-1:0]    r_busy;
    logic [3:0]           r_flags;
    logic                 r_uf;
    logic                 r_w_en;
    logic [REG_IDX_W-1:0] r_w_idx;
    logic [DATA_W-1:0]    r_w_data;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_alu_wr;
    logic                 w_nxt_en;
    logic [REG_IDX_W-1:0] w_nxt_idx;
    logic [DATA_W-1:0]    w_nxt_data;
    logic [LDQ_DEPTH-1:0] w_vld_nxt;
    logic [C_NREG-1:0]    w_busy_nxt;

    assign w_full   = (r_count == C_CNT_W'(LDQ_DEPTH));
    assign w_empty  = (r_count == '0);

    // A full queue blocks a load even if a pop happens this cycle; a memory
    // return owns the write port, so an ALU register write must wait.
    assign w_ready  = ~(ex_wb_is_load & w_full)
                    & ~(mem_r_valid & ex_wb_reg_we & ~ex_wb_is_load);
    assign w_accept = ex_wb_valid & w_ready;
    assign w_push   = w_accept & ex_wb_is_load;
    assign w_pop    = mem_r_valid & ~w_empty;
    assign w_alu_wr = w_accept & ~ex_wb_is_load & ex_wb_reg_we;

    // Select the write for the next cycle; pop and ALU write are exclusive
    always_comb begin
        w_nxt_en   = w_pop | w_alu_wr;
        w_nxt_idx  = '0;
        w_nxt_data = '0;
        if (w_pop) begin
            w_nxt_idx  = r_ldq_idx[r_rd_ptr];
            w_nxt_data = mem_r_data;
        end else if (w_alu_wr) begin
            w_nxt_idx  = ex_wb_reg_idx_dst;
            w_nxt_data = ex_wb_result;
        end
    end

    // Busy scoreboard from the slot contents after this cycle's push/pop
    always_comb begin
        w_vld_nxt = r_slot_vld;
        if (w_pop) begin
            w_vld_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_nxt[r_wr_ptr] = 1'b1;
        end
        w_busy_nxt = '0;
        for (int s = 0; s < LDQ_DEPTH; s++) begin
            if (w_vld_nxt[s]) begin
                if (w_push && (r_wr_ptr == C_PTR_W'(s))) begin
                    w_busy_nxt[ex_wb_reg_idx_dst] = 1'b1;
                end else begin
                    w_busy_nxt[r_ldq_idx[s]] = 1'b1;
                end
            end
        end
    end

    // LDQ pointers, slots and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_slot_vld <= '0;
            for (int s = 0; s < LDQ_DEPTH; s++) begin
                r_ldq_idx[s] <= '0;
            end
        end else begin
            r_slot_vld <= w_vld_nxt;
            if (w_push) begin
                r_ldq_idx[r_wr_ptr] <= ex_wb_reg_idx_dst;
                r_wr_ptr            <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_CNT_W'(1);
            end
        end
    end

    // Register-file write port, flags, busy map and underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_en   <= 1'b0;
            r_w_idx  <= '0;
            r_w_data <= '0;
            r_flags  <= 4'b0000;
            r_busy   <= '0;
            r_uf     <= 1'b0;
        end else begin
            r_w_en   <= w_nxt_en;
            r_w_idx  <= w_nxt_idx;
            r_w_data <= w_nxt_data;
            r_busy   <= w_busy_nxt;
            if (w_accept && ex_wb_flags_we) begin
                r_flags <= ex_wb_nzcv;
            end
            if (mem_r_valid && w_empty) begin
                r_uf <= 1'b1;
            end
        end
    end

    assign ex_wb_ready   = w_ready;
    assign reg_w_en      = r_w_en;
    assign reg_w_idx     = r_w_idx;
    assign reg_w_data    = r_w_data;
    assign flags_q       = r_flags;
    assign reg_busy      = r_busy;
    assign ldq_count     = r_count;
    assign ldq_underflow = r_uf;

`ifdef WB_BYPASS_EN
    assign byp_valid = w_nxt_en;
    assign byp_idx   = w_nxt_idx;
    assign byp_data  = w_nxt_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit_p
// Purpose  : Directed self-checking bench for writeback_unit_p with a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit_p;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 5;
    localparam int LDQ_DEPTH = 4;
    localparam int NREG      = 2 ** REG_IDX_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ex_wb_valid;
    logic                 ex_wb_ready;
    logic [DATA_W-1:0]    ex_wb_result;
    logic [3:0]           ex_wb_nzcv;
    logic                 ex_wb_flags_we;
    logic                 ex_wb_reg_we;
    logic                 ex_wb_is_load;
    logic [REG_IDX_W-1:0] ex_wb_reg_idx_dst;
    logic                 mem_r_valid;
    logic [DATA_W-1:0]    mem_r_data;
    logic                 reg_w_en;
    logic [REG_IDX_W-1:0] reg_w_idx;
    logic [DATA_W-1:0]    reg_w_data;
    logic [3:0]           flags_q;
    logic [NREG-1:0]      reg_busy;
    logic [2:0]           ldq_count;
    logic                 ldq_underflow;

    int n_chk = 0;
    int n_err = 0;

    writeback_unit_p #(
        .DATA_W   (DATA_W),
        .REG_IDX_W(REG_IDX_W),
        .LDQ_DEPTH(LDQ_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_wb_valid      (ex_wb_valid),
        .ex_wb_ready      (ex_wb_ready),
        .ex_wb_result     (ex_wb_result),
        .ex_wb_nzcv       (ex_wb_nzcv),
        .ex_wb_flags_we   (ex_wb_flags_we),
        .ex_wb_reg_we     (ex_wb_reg_we),
        .ex_wb_is_load    (ex_wb_is_load),
        .ex_wb_reg_idx_dst(ex_wb_reg_idx_dst),
        .mem_r_valid      (mem_r_valid),
        .mem_r_data       (mem_r_data),
        .reg_w_en         (reg_w_en),
        .reg_w_idx        (reg_w_idx),
        .reg_w_data       (reg_w_data),
        .flags_q          (flags_q),
        .reg_busy         (reg_busy),
        .ldq_count        (ldq_count),
        .ldq_underflow    (ldq_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_q[$];
    bit              m_w_en;
    int              m_w_idx;
    int              m_w_data;
    logic [3:0]      m_flags;
    bit              m_uf;

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b = '0;
        foreach (m_q[k]) b[m_q[k]] = 1'b1;
        return b;
    endfunction

    // Check outputs against the model, then advance the model by one cycle
    always @(negedge clk) begin
        bit m_ready;
        bit acc;
        if (reset) begin
            m_q.delete();
            m_w_en = 0; m_w_idx = 0; m_w_data = 0; m_flags = 4'b0; m_uf = 0;
        end
        m_ready = !((ex_wb_is_load && m_q.size() == LDQ_DEPTH) ||
                    (mem_r_valid && ex_wb_reg_we && !ex_wb_is_load));
        chk("m_ready", 64'(ex_wb_ready), 64'(m_ready));
        chk("m_w_en", 64'(reg_w_en), 64'(m_w_en));
        if (m_w_en) begin
            chk("m_w_idx", 64'(reg_w_idx), 64'(m_w_idx));
            chk("m_w_data", 64'(reg_w_data), 64'(m_w_data));
        end
        chk("m_flags", 64'(flags_q), 64'(m_flags));
        chk("m_busy", 64'(reg_busy), 64'(model_busy()));
        chk("m_count", 64'(ldq_count), 64'(m_q.size()));
        chk("m_underflow", 64'(ldq_underflow), 64'(m_uf));
        if (!reset) begin
            acc = ex_wb_valid && m_ready;
            m_w_en = 0; m_w_idx = 0; m_w_data = 0;
            if (mem_r_valid) begin
                if (m_q.size() > 0) begin
                    m_w_en   = 1;
                    m_w_idx  = m_q.pop_front();
                    m_w_data = int'(mem_r_data);
                end else begin
                    m_uf = 1;
                end
            end
            if (acc && ex_wb_is_load) begin
                m_q.push_back(int'(ex_wb_reg_idx_dst));
            end else if (acc && ex_wb_reg_we) begin
                m_w_en   = 1;
                m_w_idx  = int'(ex_wb_reg_idx_dst);
                m_w_data = int'(ex_wb_result);
            end
            if (acc && ex_wb_flags_we) m_flags = ex_wb_nzcv;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [15:0] res, input logic [3:0] nz,
                         input bit fwe, input bit rwe, input bit ld,
                         input logic [4:0] dst, input bit mrv, input logic [15:0] md);
        ex_wb_valid       = v;
        ex_wb_result      = res;
        ex_wb_nzcv        = nz;
        ex_wb_flags_we    = fwe;
        ex_wb_reg_we      = rwe;
        ex_wb_is_load     = ld;
        ex_wb_reg_idx_dst = dst;
        mem_r_valid       = mrv;
        mem_r_data        = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 16'h0, 4'h0, 0, 0, 0, 5'd0, 0, 16'h0);
    endtask

    task automatic alu(input logic [4:0] dst, input logic [15:0] res);
        drive(1, res, 4'h0, 0, 1, 0, dst, 0, 16'h0);
    endtask

    task automatic load(input logic [4:0] dst);
        drive(1, 16'h0, 4'h0, 0, 0, 1, dst, 0, 16'h0);
    endtask

    task automatic ret(input logic [15:0] d);
        drive(0, 16'h0, 4'h0, 0, 0, 0, 5'd0, 1, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_w_en", 64'(reg_w_en), 64'd0);
        chk("rst_flags", 64'(flags_q), 64'd0);
        chk("rst_busy", 64'(reg_busy), 64'd0);
        chk("rst_count", 64'(ldq_count), 64'd0);
        chk("rst_uf", 64'(ldq_underflow), 64'd0);

        // ALU write, latency 1, single-cycle pulse
        alu(5'd3, 16'h1234); tick();
        chk("alu_en", 64'(reg_w_en), 64'd1);
        chk("alu_idx", 64'(reg_w_idx), 64'd3);
        chk("alu_data", 64'(reg_w_data), 64'h1234);
        idle(); tick();
        chk("alu_pulse", 64'(reg_w_en), 64'd0);

        // Single load and return
        load(5'd7); tick();
        chk("ld7_busy", 64'(reg_busy[7]), 64'd1);
        chk("ld7_count", 64'(ldq_count), 64'd1);
        idle(); tick();
        ret(16'hBEEF); tick();
        chk("ld7_idx", 64'(reg_w_idx), 64'd7);
        chk("ld7_data", 64'(reg_w_data), 64'hBEEF);
        chk("ld7_free", 64'(reg_busy[7]), 64'd0);

        // Fill the queue, fifth load is refused, returns retire in order
        for (int i = 1; i <= 4; i++) begin
            load(5'(i)); tick();
        end
        chk("full_count", 64'(ldq_count), 64'd4);
        load(5'd5); #1;
        chk("full_ready", 64'(ex_wb_ready), 64'd0);
        tick();
        chk("full_hold", 64'(ldq_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            ret(16'hA + 16'(i)); tick();
            chk("fifo_idx", 64'(reg_w_idx), 64'(i + 1));
            chk("fifo_data", 64'(reg_w_data), 64'(16'hA + 16'(i)));
        end
        idle(); tick();
        chk("drain_count", 64'(ldq_count), 64'd0);

        // Port conflict: memory return wins, ALU write follows
        load(5'd9); tick();
        drive(1, 16'h0055, 4'h0, 0, 1, 0, 5'd5, 1, 16'h5555); #1;
        chk("conf_ready", 64'(ex_wb_ready), 64'd0);
        tick();
        chk("conf_mem_idx", 64'(reg_w_idx), 64'd9);
        chk("conf_mem_data", 64'(reg_w_data), 64'h5555);
        alu(5'd5, 16'h0055); tick();
        chk("conf_alu_idx", 64'(reg_w_idx), 64'd5);
        chk("conf_alu_data", 64'(reg_w_data), 64'h0055);
        idle(); tick();

        // Flags, discarded beat, underflow
        drive(1, 16'h0, 4'b1001, 1, 0, 0, 5'd0, 0, 16'h0); tick();
        chk("flags", 64'(flags_q), 64'b1001);
        drive(1, 16'hFFFF, 4'b1111, 0, 0, 0, 5'd2, 0, 16'h0); tick();
        chk("discard_flags", 64'(flags_q), 64'b1001);
        chk("discard_en", 64'(reg_w_en), 64'd0);
        ret(16'hDEAD); tick();
        chk("uf_en", 64'(reg_w_en), 64'd0);
        chk("uf_set", 64'(ldq_underflow), 64'd1);
        idle(); tick();
        chk("uf_sticky", 64'(ldq_underflow), 64'd1);

        // Two loads to the same register
        drive(1, 16'h0, 4'b0110, 1, 0, 1, 5'd6, 0, 16'h0); tick();
        chk("ld_flags", 64'(flags_q), 64'b0110);
        load(5'd6); tick();
        chk("dup_count", 64'(ldq_count), 64'd2);
        ret(16'h0666); tick();
        chk("dup_busy1", 64'(reg_busy[6]), 64'd1);
        chk("dup_idx1", 64'(reg_w_idx), 64'd6);
        ret(16'h0667); tick();
        chk("dup_busy0", 64'(reg_busy[6]), 64'd0);

        // Push and pop of the same index in one cycle
        load(5'd8); tick();
        drive(1, 16'h0, 4'h0, 0, 0, 1, 5'd8, 1, 16'h0888); tick();
        chk("pp_busy", 64'(reg_busy[8]), 64'd1);
        chk("pp_count", 64'(ldq_count), 64'd1);
        chk("pp_data", 64'(reg_w_data), 64'h0888);
        ret(16'h0889); tick();
        chk("pp_free", 64'(reg_busy[8]), 64'd0);
        chk("pp_count0", 64'(ldq_count), 64'd0);

        // Asynchronous reset with loads pending
        load(5'd10); tick();
        load(5'd11); tick();
        idle();
        reset = 1'b1; #1;
        chk("arst_count", 64'(ldq_count), 64'd0);
        chk("arst_busy", 64'(reg_busy), 64'd0);
        chk("arst_uf", 64'(ldq_underflow), 64'd0);
        chk("arst_flags", 64'(flags_q), 64'd0);
        chk("arst_en", 64'(reg_w_en), 64'd0);
        tick();
        reset = 1'b0;
        ret(16'h1111); tick();
        chk("post_en", 64'(reg_w_en), 64'd0);
        chk("post_uf", 64'(ldq_underflow), 64'd1);
        idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
